sha3_padder: RTL

- Upstream feeder of the 1088-bit block shift buffer in the SHA3-256 absorb path.
- Accepts a byte-serial message and packs it into 136-bit words, 17 bytes per word.
- Applies SHA3 pad10*1 with domain suffix, so every message becomes a whole number of 8-word (1088-bit) blocks.
- Emits one word per valid/ready handshake. Word 0 of each block is emitted first, so it ends in the low 136 bits of the downstream block.

---
 rtl/sha3_padder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sha3_padder.sv
// sha3_padder
// Packs a byte-serial message into 136-bit words (17 bytes each) and applies
// SHA3 pad10*1 with a domain suffix. The padded output is always a whole number
// of 8-word (1088-bit) rate blocks. Word 0 of each block is emitted first.
//
// Ports
//   scan_clk    : clock, all state on the rising edge
//   reset       : asynchronous, active-high reset
//   din         : message byte
//   din_valid   : din/din_last/din_empty valid this cycle
//   din_last    : final beat of the message
//   din_empty   : with din_last, the beat carries no data byte
//   din_ready   : beat accepted when din_valid && din_ready
//   word_out    : packed word, byte k at bits [8k+7:8k]
//   word_valid  : word_out valid
//   word_ready  : word accepted when word_valid && word_ready
//   block_end   : with word_valid, this is word 7 of a block
//   msg_end     : with word_valid, this is the final word of the padded message
//   dbg_state   : current FSM state (FILL=0, PAD=1, EMIT=2)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. A producer holding valid keeps its payload stable until that edge. Both
// din_ready and word_valid are decoded from registered state only, so neither
// depends combinationally on the other side's valid/ready.
module sha3_padder #(
  parameter int         WORD_BYTES      = 17,
  parameter int         WORDS_PER_BLOCK = 8,
  parameter logic [7:0] DSUFFIX         = 8'h06
) (
  input  logic                    scan_clk,
  input  logic                    reset,
  input  logic [7:0]              din,
  input  logic                    din_valid,
  input  logic                    din_last,
  input  logic                    din_empty,
  output logic                    din_ready,
  output logic [8*WORD_BYTES-1:0] word_out,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    block_end,
  output logic                    msg_end,
  output logic [1:0]              dbg_state
);

  localparam int W    = 8 * WORD_BYTES;
  localparam int BC_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int WC_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(WORD_BYTES - 1);
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PAD  = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  state_t            state_q,       state_d;
  logic [W-1:0]      word_q,        word_d;
  logic [BC_W-1:0]   byte_cnt_q,    byte_cnt_d;
  logic [WC_W-1:0]   word_cnt_q,    word_cnt_d;
  // Last data byte filled its word: DSUFFIX still has to go at byte 0 of the
  // next word once the current one has been handed off.
  logic              pad_pending_q, pad_pending_d;
  // DSUFFIX already placed; the remaining words of the block are synthesised
  // without consuming input.
  logic              gen_q,         gen_d;
  // The word currently held is the final word of the padded message.
  logic              msg_end_q,     msg_end_d;
  // Holds din_ready low until the first edge after reset is released.
  logic              started_q;

  logic              din_accept;
  logic              word_accept;

  assign din_ready   = started_q && (state_q == ST_FILL);
  assign din_accept  = din_valid && din_ready;
  assign word_valid  = (state_q == ST_EMIT);
  assign word_accept = word_valid && word_ready;
  assign word_out    = word_q;
  assign block_end   = word_valid && (word_cnt_q == LAST_WORD);
  assign msg_end     = word_valid && msg_end_q;
  assign dbg_state   = state_q;

  always_ff @(posedge scan_clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_FILL;
      word_q        <= '0;
      byte_cnt_q    <= '0;
      word_cnt_q    <= '0;
      pad_pending_q <= 1'b0;
      gen_q         <= 1'b0;
      msg_end_q     <= 1'b0;
      started_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      byte_cnt_q    <= byte_cnt_d;
      word_cnt_q    <= word_cnt_d;
      pad_pending_q <= pad_pending_d;
      gen_q         <= gen_d;
      msg_end_q     <= msg_end_d;
      started_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    byte_cnt_d    = byte_cnt_q;
    word_cnt_d    = word_cnt_q;
    pad_pending_d = pad_pending_q;
    gen_d         = gen_q;
    msg_end_d     = msg_end_q;

    case (state_q)
      ST_FILL: begin
        if (din_accept) begin
          if (din_last && din_empty) begin
            // Length known after the last byte: pad at the current position.
            state_d = ST_PAD;
          end else if (din_empty) begin
            // din_empty without din_last carries nothing; swallow the beat.
            state_d = ST_FILL;
          end else begin
            for (int k = 0; k < WORD_BYTES; k++) begin
              if (BC_W'(k) == byte_cnt_q) word_d[8*k +: 8] = din;
            end
            if (byte_cnt_q == LAST_BYTE) begin
              state_d       = ST_EMIT;
              pad_pending_d = din_last;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
              if (din_last) state_d = ST_PAD;
            end
          end
        end
      end

      ST_PAD: begin
        // DSUFFIX at the pad position, zeros above it; the block's final byte
        // also carries the closing 0x80 (giving 0x86 when both coincide).
        for (int k = 0; k < WORD_BYTES; k++) begin
          if (BC_W'(k) == byte_cnt_q)     word_d[8*k +: 8] = DSUFFIX;
          else if (BC_W'(k) > byte_cnt_q) word_d[8*k +: 8] = 8'h00;
        end
        if (word_cnt_q == LAST_WORD) begin
          word_d[W-1 -: 8] = word_d[W-1 -: 8] | 8'h80;
          msg_end_d        = 1'b1;
          gen_d            = 1'b0;
        end else begin
          msg_end_d = 1'b0;
          gen_d     = 1'b1;
        end
        pad_pending_d = 1'b0;
        state_d       = ST_EMIT;
      end

      ST_EMIT: begin
        if (word_accept) begin
          word_d     = '0;
          byte_cnt_d = '0;
          word_cnt_d = (word_cnt_q == LAST_WORD) ? '0 : word_cnt_q + 1'b1;
          if (msg_end_q) begin
            state_d   = ST_FILL;
            msg_end_d = 1'b0;
            gen_d     = 1'b0;
          end else if (pad_pending_q) begin
            state_d = ST_PAD;
          end else if (gen_q) begin
            // Padding filler: all zero except the block's last word.
            state_d = ST_EMIT;
            if (word_cnt_d == LAST_WORD) begin
              word_d[W-1 -: 8] = 8'h80;
              msg_end_d        = 1'b1;
            end
          end else begin
            state_d = ST_FILL;
          end
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

endmodule
